// File: rtl/data_mem_responder.sv
// On-chip data memory acting as the responder on the core's memory request interface.
// Captures a start-pulsed request, waits WAIT_STATES cycles, then answers with a one-cycle done.
module data_mem_responder #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             BUS_WIDTH   = 32,
    parameter int unsigned             DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
    parameter int unsigned             WAIT_STATES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_start_req_i,
    input  logic                   mem_wen_i,
    input  logic [ADDR_WIDTH-1:0]  mem_adr_i,
    input  logic [BUS_WIDTH-1:0]   mem_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] mem_sel_i,
    output logic [BUS_WIDTH-1:0]   mem_rdata_o,
    output logic                   mem_done_req_o,
    output logic                   mem_err_o
);

    localparam int unsigned LANES     = BUS_WIDTH / 8;
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]       sel_q, sel_d;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic [BUS_WIDTH-1:0]   ram_q [DEPTH_WORDS];

    // Range check in ADDR_WIDTH+1 bits so BASE_ADDR + size cannot wrap.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] a_x;
        logic [ADDR_WIDTH:0] lo;
        logic [ADDR_WIDTH:0] hi;
        a_x = {1'b0, a};
        lo  = {1'b0, BASE_ADDR};
        hi  = lo + (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
        return (a_x >= lo) && (a_x < hi);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_start_req_i) begin
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data and error are sampled on entry to RESP, from the request being completed.
    always_comb begin
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = (state_d == RESP);
        if (state_q == IDLE && mem_start_req_i) begin
            wen_d   = mem_wen_i;
            adr_d   = mem_adr_i;
            wdata_d = mem_wdata_i;
            sel_d   = mem_sel_i;
            cnt_d   = WAIT_LOAD;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_d == RESP) begin
            err_d   = !in_range(adr_d);
            rdata_d = in_range(adr_d) ? ram_q[word_idx(adr_d)] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && state_q == RESP && wen_q && !err_q) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (sel_q[k]) begin
                    ram_q[word_idx(adr_q)][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign mem_rdata_o    = rdata_q;
    assign mem_done_req_o = done_q;
    assign mem_err_o      = err_q;

endmodule
